fan_pwm_gen: RTL and testbench
==============================

// Module: fan_pwm_gen
// PURPOSE
//   Downstream stage of the duty-selection logic. Takes the 7-bit duty command (0..100 %)
//   and drives the 4-wire fan PWM pin. Applies a slew-rate limiter (soft ramp) so the fan
//   speed never jumps. Duty updates are glitch-free: they take effect only at PWM period
//   boundaries. Reports the applied duty and ramp status for the display/UART status path.
// PARAMETERS
//   CLK_FREQ      50_000_000  sys_clk frequency, Hz
//   PWM_FREQ      25_000      PWM frequency, Hz; PERIOD = CLK_FREQ/PWM_FREQ (>=2, integer)
//   RAMP_PERIODS  250         PWM periods per 1 % ramp step (>=1)
//   KICK_PERIODS  12_500      length of kick-start burst in PWM periods (KICKSTART_EN only)
// PORTS
//   sys_clk       in   1   system clock
//   sys_rst       in   1   synchronous reset, active-high
//   duty_data     in   7   target duty, percent; values >100 clamp to 100
//   pwm_out       out  1   fan PWM drive, high = on
//   cur_duty      out  7   duty applied in the current PWM period, percent
//   period_start  out  1   1-cycle pulse on the first cycle of each PWM period
//   ramping       out  1   1 while cur_duty != clamped target (or kick active)
// BEHAVIOUR
//   Reset (sys_clk edge with sys_rst=1): pwm_out=0, cur_duty=0, period_start=0, ramping=0;
//     period counter, ramp counter, kick counter and threshold cleared; FSM -> IDLE.
//     Reset mid-period aborts the period immediately; no partial pulse after the reset edge.
//   Period counter cnt: 0..PERIOD-1, wraps to 0; period_start=1 on the cycle cnt==0.
//   Target: tgt = (duty_data > 100) ? 100 : duty_data, sampled every cycle (no handshake).
//   Threshold: at the cycle cnt wraps to 0, thr <= (cur_duty_next * PERIOD) / 100,
//     truncating; compute width must hold 100*PERIOD without overflow.
//   Output: registered, pwm_out = (cnt < thr). duty 0 -> constant 0; duty 100 -> constant 1.
//     Latency: a new cur_duty is visible on pwm_out from the first cycle of the next period.
//   Ramp: ramp counter counts PWM periods; on every RAMP_PERIODS-th period boundary,
//     cur_duty moves 1 toward tgt (+1 if below, -1 if above, hold if equal).
//     Target change mid-ramp: direction re-evaluated at the next step; no reversal overshoot.
//     Ramp counter restarts whenever cur_duty == tgt, so the first step after a new target
//     occurs RAMP_PERIODS periods later.
//   FSM states:
//     IDLE : cur_duty==0 and tgt==0; pwm_out=0.        tgt!=0 -> RUN (or KICK if enabled)
//     KICK : only with KICKSTART_EN (see CONFIGURATION).  -> RUN when kick count expires
//     RUN  : normal ramp/PWM.                          cur_duty==0 and tgt==0 -> IDLE
//   All state changes happen on period boundaries only.
//   ramping = (cur_duty != tgt) || (state==KICK), registered.
// CONFIGURATION
//   KICKSTART_EN defined: on IDLE->KICK, pwm_out is forced to 100 % for KICK_PERIODS
//     whole periods to break stiction. cur_duty reports 100 during kick. At kick end,
//     cur_duty is loaded with tgt directly, with no ramp-down from 100. If tgt returns to 0
//     during kick, the kick still completes; then RUN, which falls to IDLE.
//   KICKSTART_EN undefined: KICK state, kick counter and KICK_PERIODS logic absent;
//     IDLE -> RUN directly; cur_duty ramps from 0.
// TESTING (bench params: CLK_FREQ=1000, PWM_FREQ=100 -> PERIOD=10, RAMP_PERIODS=2, KICK_PERIODS=3)
//   1. Reset held 5 cycles, duty_data=50 -> pwm_out=0, cur_duty=0, period_start=0 throughout.
//   2. duty_data 0->5 in RUN, no kick -> cur_duty increments 1 per 2 periods to 5; at 5 %,
//      thr=0 so pwm_out=0; at duty 10, 1 high cycle per 10.
//   3. duty_data=127 -> tgt clamps to 100; after ramp completes, pwm_out constant 1,
//      ramping=0.
//   4. Ramping to 100, at cur_duty=60 set duty_data=40 -> next step goes to 59, settles at 40;
//      pwm_out width changes only at cnt==0.
//   5. sys_rst pulsed mid-period with pwm_out=1 -> pwm_out=0 the cycle after reset edge;
//      restart from IDLE.
//   6. KICKSTART_EN, duty_data 0->30 -> 3 full-high periods with cur_duty=100, then
//      cur_duty=30, thr=3.

Source files
------------

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: slew-limited, period-glitch-free fan PWM driver; define KICKSTART_EN to add a full-duty kick-start burst
module fan_pwm_gen #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int PWM_FREQ     = 25_000,
  parameter int RAMP_PERIODS = 250,
  parameter int KICK_PERIODS = 12_500
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [6:0] duty_data,
  output logic       pwm_out,
  output logic [6:0] cur_duty,
  output logic       period_start,
  output logic       ramping
);
  localparam int PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int DW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(100 * PERIOD + 1);
  localparam int RW = $clog2(RAMP_PERIODS + 1);

  if (PERIOD < 2 || RAMP_PERIODS < 1 || KICK_PERIODS < 1) begin : g_bad_cfg
    $error("fan_pwm_gen: invalid PERIOD, RAMP_PERIODS or KICK_PERIODS");
  end

`ifdef KICKSTART_EN
  localparam int KW = $clog2(KICK_PERIODS + 1);
  typedef enum logic [1:0] {IDLE, KICK, RUN} state_t;
  logic [KW-1:0] kcnt, kcnt_next;
  logic          kick_done;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t          st, st_next;
  logic [DW-1:0]   cnt, cnt_next, thr, thr_next;
  logic [RW-1:0]   rcnt, rcnt_next;
  logic [TW-1:0]   prod;
  logic [6:0]      tgt, cur_next;
  logic            wrap, last_step, kicking;

  // State register
  always_ff @(posedge sys_clk)
    st <= sys_rst ? IDLE : st_next;

  // Next state, period counter, ramp step and kick sequencing; everything moves only on a period wrap
  always_comb begin
    tgt = duty_data > 7'd100 ? 7'd100 : duty_data;
    wrap = cnt == DW'(PERIOD - 1);
    cnt_next = wrap ? '0 : cnt + 1'b1;
    last_step = rcnt == RW'(RAMP_PERIODS - 1);
    st_next = st;
    cur_next = cur_duty;
    rcnt_next = cur_duty == tgt ? '0 : rcnt;
`ifdef KICKSTART_EN
    kick_done = kcnt == KW'(KICK_PERIODS - 1);
    kcnt_next = kcnt;
`endif
    if (wrap && cur_duty != tgt) begin
      rcnt_next = last_step ? '0 : rcnt + 1'b1;
      cur_next = !last_step ? cur_duty : cur_duty < tgt ? cur_duty + 7'd1 : cur_duty - 7'd1;
    end
    if (wrap)
      case (st)
`ifdef KICKSTART_EN
        IDLE: if (tgt != 7'd0) begin
          st_next = KICK;
          cur_next = 7'd100;
          rcnt_next = '0;
          kcnt_next = '0;
        end
        KICK: begin
          st_next = kick_done ? RUN : KICK;
          cur_next = kick_done ? tgt : 7'd100;
          rcnt_next = '0;
          kcnt_next = kcnt + 1'b1;
        end
`else
        IDLE: st_next = tgt == 7'd0 ? IDLE : RUN;
`endif
        default: st_next = cur_next == 7'd0 && tgt == 7'd0 ? IDLE : RUN;
      endcase
  end

`ifdef KICKSTART_EN
  assign kicking = st_next == KICK;
`else
  assign kicking = 1'b0;
`endif

  assign prod = TW'(cur_next) * TW'(PERIOD);
  assign thr_next = wrap ? DW'(prod / TW'(100)) : thr;

  // Datapath registers; output compare is registered so pwm_out tracks cnt with no decode glitches
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      cnt <= '0;
      thr <= '0;
      rcnt <= '0;
      cur_duty <= '0;
      pwm_out <= 1'b0;
      period_start <= 1'b0;
      ramping <= 1'b0;
`ifdef KICKSTART_EN
      kcnt <= '0;
`endif
    end else begin
      cnt <= cnt_next;
      thr <= thr_next;
      rcnt <= rcnt_next;
      cur_duty <= cur_next;
      pwm_out <= cnt_next < thr_next;
      period_start <= wrap;
      ramping <= cur_next != tgt || kicking;
`ifdef KICKSTART_EN
      kcnt <= kcnt_next;
`endif
    end
endmodule

// File: tb/tb_fan_pwm_gen.sv
// tb_fan_pwm_gen: scoreboard bench for fan_pwm_gen with a cycle model feeding an expected-output queue
module tb_fan_pwm_gen;
  localparam int P = 10, R = 2, K = 3;
`ifdef KICKSTART_EN
  localparam bit KE = 1'b1;
`else
  localparam bit KE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] duty_data = 7'd50;
  logic pwm_out, period_start, ramping;
  logic [6:0] cur_duty;
  int n_checks = 0, n_errors = 0;
  typedef struct packed { logic pwm; logic [6:0] cur; logic ps; logic ramp; } exp_t;
  exp_t q[$];
  exp_t e;
  int m_pos = 0, m_duty = 0, m_thr = 0, m_rc = 0, m_mode = 0, m_kc = 0;

  fan_pwm_gen #(.CLK_FREQ(1000), .PWM_FREQ(100), .RAMP_PERIODS(R), .KICK_PERIODS(K)) dut (
    .sys_clk(clk), .sys_rst(rst), .duty_data(duty_data), .pwm_out(pwm_out),
    .cur_duty(cur_duty), .period_start(period_start), .ramping(ramping)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 kick, 2 run; pushes the outputs expected after each edge
  always @(posedge clk) begin : model
    int t;
    bit b;
    if (rst) begin
      m_pos = 0; m_duty = 0; m_thr = 0; m_rc = 0; m_mode = 0; m_kc = 0;
      q.push_back('0);
    end else begin
      t = duty_data > 7'd100 ? 100 : int'(duty_data);
      b = m_pos == P - 1;
      m_pos = b ? 0 : m_pos + 1;
      if (!b) begin
        if (m_duty == t) m_rc = 0;
      end else if (m_mode == 1) begin
        m_kc++;
        if (m_kc == K) begin m_mode = 2; m_duty = t; end
      end else if (m_mode == 0 && t != 0 && KE) begin
        m_mode = 1; m_kc = 0; m_duty = 100; m_rc = 0;
      end else begin
        if (m_duty == t) m_rc = 0;
        else begin
          m_rc++;
          if (m_rc == R) begin m_rc = 0; m_duty += m_duty < t ? 1 : -1; end
        end
        if (m_mode == 0 && t != 0) m_mode = 2;
        else if (m_mode == 2 && m_duty == 0 && t == 0) m_mode = 0;
      end
      if (b) m_thr = m_duty * P / 100;
      q.push_back({m_pos < m_thr, 7'(m_duty), b, m_duty != t || m_mode == 1});
    end
  end

  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pwm_out", int'(pwm_out), int'(e.pwm));
      check("cur_duty", int'(cur_duty), int'(e.cur));
      check("period_start", int'(period_start), int'(e.ps));
      check("ramping", int'(ramping), int'(e.ramp));
    end

  task automatic wait_duty(input int v, input int lim);
    int i = 0;
    while (int'(cur_duty) != v && i < lim) begin @(negedge clk); i++; end
    check("reach_duty", int'(cur_duty), v);
  endtask

  task automatic count_high(input string tag, input int exp);
    int i = 0, n = 0;
    while (!period_start && i < 3 * P) begin @(negedge clk); i++; end
    check({tag, "_sync"}, int'(period_start), 1);
    for (int j = 0; j < P; j++) begin n += int'(pwm_out); @(negedge clk); end
    check(tag, n, exp);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_cur", int'(cur_duty), 0);
    check("rst_ps", int'(period_start), 0);
    rst = 1'b0;
    duty_data = 7'd0;
    repeat (3 * P) @(negedge clk);
    check("idle_ramping", int'(ramping), 0);
    duty_data = 7'd5;
    wait_duty(5, 30 * P);
    count_high("hi_at_5", 0);
    duty_data = 7'd10;
    wait_duty(10, 30 * P);
    count_high("hi_at_10", 1);
    duty_data = 7'd127;
    wait_duty(60, 150 * P);
    duty_data = 7'd40;
    wait_duty(59, 6 * P);
    wait_duty(40, 60 * P);
    duty_data = 7'd127;
    wait_duty(100, 150 * P);
    check("ramp_done", int'(ramping), 0);
    count_high("hi_at_100", P);
    repeat (4) @(negedge clk);
    check("pre_rst_pwm", int'(pwm_out), 1);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_pwm", int'(pwm_out), 0);
    check("post_rst_cur", int'(cur_duty), 0);
    rst = 1'b0;
    repeat (6 * P) @(negedge clk);
`ifdef KICKSTART_EN
    rst = 1'b1;
    duty_data = 7'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * P) @(negedge clk);
    duty_data = 7'd30;
    wait_duty(100, 3 * P);
    for (int p = 0; p < K; p++) count_high("kick_hi", P);
    check("kick_end_cur", int'(cur_duty), 30);
    count_high("hi_at_30", 3);
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
